// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the digit-serial add/sub datapath.
package alu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CHUNK_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of chunk cycles per operation.
  function automatic int calc_n(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk counter width, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_sub_serial_if.sv
// Operand/result bundle for add_sub_serial.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the sender holds valid and its payload stable until that edge.
interface add_sub_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero, neg
  );
endinterface

// File: rtl/add_sub_serial_slice.sv
// Combinational CHUNK-bit ripple adder; also reports the carry into its MSB
// so the top can derive signed overflow on the final chunk.
module add_sub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  logic c;

  always_comb begin
    sum   = '0;
    c     = cin;
    c_msb = cin;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cout = c;
  end
endmodule

// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor: CHUNK bits per clock, WIDTH/CHUNK cycles per
// operation, one shared slice adder, valid/ready on both sides.
module add_sub_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  add_sub_serial_if.slave      bus,
  output state_t               state_dbg
);
  localparam int N  = calc_n(WIDTH, CHUNK);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("add_sub_serial: WIDTH must be a positive multiple of CHUNK");
  end

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, zacc_q, cout_q, ovf_q, zero_q;

  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             c_out, c_msb;
  int               idx;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx     = int'(cnt_q) * CHUNK;
  assign a_chunk = a_q[idx +: CHUNK];
  assign b_chunk = b_q[idx +: CHUNK];

  add_sub_slice #(.CHUNK(CHUNK)) u_slice (
    .a     (a_chunk),
    .b     (b_chunk),
    .cin   (carry_q),
    .sum   (sum_chunk),
    .cout  (c_out),
    .c_msb (c_msb)
  );

  // Subtraction runs as a + ~b + ~borrow, so the slice only ever adds.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.cin ^ bus.sub;
            zacc_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          s_q[idx +: CHUNK] <= sum_chunk;
          carry_q           <= c_out;
          zacc_q            <= zacc_q & (sum_chunk == '0);
          if (cnt_q == LAST) begin
            cout_q <= c_out;
            ovf_q  <= c_msb ^ c_out;
            zero_q <= zacc_q & (sum_chunk == '0);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.s     = s_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign bus.zero  = zero_q;
  assign bus.neg   = s_q[WIDTH-1];
  assign state_dbg = state_q;
endmodule

// File: doc/add_sub_serial.md
Name: add_sub_serial

Overview:
- Parametrised digit-serial adder/subtractor: WIDTH-bit operands, CHUNK bits processed per clock, N = WIDTH/CHUNK cycles per operation.
- Successor to the fixed 8-bit ripple add/sub. Adds:
  - a separate mode select and carry/borrow-in
  - a valid/ready handshake on both input and output sides
  - status flags: carry, signed overflow, zero, negative
- Sits in the ALU datapath where area matters more than single-cycle latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH. CHUNK = WIDTH gives N = 1.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  minuend / augend
- b  in  WIDTH  subtrahend / addend
- sub  in  1  0: s = a + b + cin; 1: s = a - b - cin
- cin  in  1  carry-in (sub=0) or borrow-in (sub=1)
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes result
- s  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  raw carry out of MSB; for sub, 1 = no borrow
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB
- zero  out  1  s == 0
- neg  out  1  s[WIDTH-1]

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; s, cout, ovf, zero, neg = 0; chunk counter = 0. Reset aborts any operation in flight with no partial result delivered.
- States:
  - IDLE: in_ready=1. On an edge with in_valid=1:
    - latch a, sub, and b (latched as ~b when sub=1)
    - carry register <= cin when sub=0, ~cin when sub=1
    - zero accumulator <= 1, counter <= 0
    - go to RUN
  - RUN: each edge processes chunk k = counter, bits [k*CHUNK +: CHUNK]:
    - s chunk <= a chunk + b' chunk + carry
    - carry <= chunk carry-out
    - zero accumulator &= (s chunk == 0)
    - counter++
    - On the edge processing k = N-1: also capture carry-into-MSB for ovf, then go to DONE.
    - in_ready=0 and out_valid=0 throughout RUN.
  - DONE: out_valid=1; s and all flags stable. On an edge with out_ready=1, go to IDLE (out_valid=0 next cycle). On out_ready=0, hold indefinitely.
- Latency: the acceptance edge plus N further edges. out_valid is visible in the cycle after the Nth RUN edge, so throughput is one operation per N+2 cycles with out_ready held high.
- No overlap: a new operand is accepted only in IDLE. in_valid outside IDLE is ignored; the producer must hold it.
- Operands are captured at acceptance; changes to a, b, sub or cin during RUN/DONE have no effect.
- s and flags keep their last value in IDLE; only out_valid qualifies them.
- The chunk index wraps only via reset or the DONE-to-IDLE transition; no other counter wrap is possible.
- Arithmetic is unsigned modulo 2^WIDTH. Flags are defined for both unsigned (cout) and signed (ovf, neg) interpretation.

Decomposition:
- Shared package alu_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - localparam N = WIDTH/CHUNK and counter width $clog2(N) (minimum 1)
  - elaboration check WIDTH % CHUNK == 0
- One sub-module, add_sub_slice: combinational CHUNK-bit ripple adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, c_msb (carry into the slice MSB).
  - Instanced once; reused every cycle.

Test Plan (WIDTH=16, CHUNK=4, N=4 unless stated):
- Add: a=0x1234, b=0x0FFF, sub=0, cin=0 -> s=0x2233, cout=0, ovf=0, zero=0, neg=0. out_valid rises exactly 4 edges after the acceptance edge.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=0 -> s=0xFFFE, cout=0, neg=1, ovf=0. Repeat with cin=1 -> s=0xFFFD.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, ovf=1, neg=1, cout=0. Then a=0xA5A5, b=0xA5A5, sub=1 -> s=0x0000, zero=1, cout=1, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid, a and b -> s and flags stable, in_ready=0, no new acceptance. Release out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst for one cycle after 2 RUN edges -> next cycle out_valid=0, in_ready=1, s=0. A following op 0x00FF+0x0001 gives 0x0100.
- Parameter sweep: CHUNK=16 (N=1) and CHUNK=1 (N=16). Run 1000 random ops with random out_ready, checked against a reference model for s, cout, ovf, zero and neg.
